// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_pkg: shared widths, the write-back record type and the round-robin
// index helper for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_write_t;

    // Next index in a ring of n requesters, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: requester handshake, hazard stall and the RF write port.
// master = requesters/hazard side, slave = arbiter.
interface rf_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]     req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wb_stall;
    logic [REG_ADDR_W-1:0]         RdAddr;
    logic [DATA_W-1:0]             RdData;
    logic                          RegWrite;

    modport master (
        output req_valid, req_addr, req_data, wb_stall,
        input  req_ready, RdAddr, RdData, RegWrite
    );

    modport slave (
        input  req_valid, req_addr, req_data, wb_stall,
        output req_ready, RdAddr, RdData, RegWrite
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over a valid vector, plus the
// last_grant pointer, which moves only when a grant is actually issued.
module rr_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               stall,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] last_grant;
    int unsigned      idx;

    // Search from last_grant+1 with wrap; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        grant_any = 1'b0;
        idx       = 32'(last_grant);
        if (!rst && !stall) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = rr_next(idx, NUM_REQ);
                if (!grant_any && valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = IDX_W'(idx);
                    grant_any  = 1'b1;
                end
            end
        end
    end

    // Pointer parks on NUM_REQ-1 after reset so requester 0 is first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between
// NUM_REQ write-back requesters. The winner's write is registered onto
// RdAddr/RdData/RegWrite and committed by the RF on the following negedge.
// conflict_cnt saturates and counts unstalled cycles with >=2 requesters.
// Optional: RF_WB_ZERO_FILTER_EN suppresses RegWrite for writes to R0 while
// still granting them.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_wb_arbiter_if.slave        bus,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    wb_write_t          win;
    logic               wr_en;
    logic               contend;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .valid     (bus.req_valid),
        .stall     (bus.wb_stall),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.req_ready = grant;

    // Select the granted requester's destination and data.
    always_comb begin
        win.addr = bus.req_addr[REG_ADDR_W*int'(grant_idx) +: REG_ADDR_W];
        win.data = bus.req_data[DATA_W*int'(grant_idx) +: DATA_W];
    end

`ifdef RF_WB_ZERO_FILTER_EN
    assign wr_en = (win.addr != REG_ZERO);
`else
    assign wr_en = 1'b1;
`endif

    assign contend = ($countones(bus.req_valid) >= 2) && !bus.wb_stall;

    // RF write port: load on grant, otherwise drop RegWrite and hold addr/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RdAddr   <= '0;
            bus.RdData   <= '0;
            bus.RegWrite <= 1'b0;
        end else if (grant_any) begin
            bus.RdAddr   <= win.addr;
            bus.RdData   <= win.data;
            bus.RegWrite <= wr_en;
        end else begin
            bus.RegWrite <= 1'b0;
        end
    end

    // Saturating contention counter; stalled cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (contend && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // A pending request must keep valid, addr and data until accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
            (bus.req_valid[i]
             && $stable(bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W])
             && $stable(bus.req_data[i*DATA_W +: DATA_W])));
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized and directed stimulus against a reference
// model of the write-back arbiter; expected writes and counter values are
// queued and checked by an independent monitor.
module tb_rf_wb_arbiter;

    localparam int unsigned N   = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NUM_REQ(N)) bus();

    rf_wb_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int unsigned due;
    } wr_t;

    wr_t         wq[$];
    int unsigned cq[$];

    logic [N-1:0] pend_v;
    logic [4:0]   pend_a [N];
    logic [31:0]  pend_d [N];
    int unsigned  last_g;
    int unsigned  cnt_m;
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic         running = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // New request on an idle requester; a pending one is left untouched.
    task automatic arm(input int unsigned i, input logic [4:0] a, input logic [31:0] d);
        if (!pend_v[i]) begin
            pend_v[i] = 1'b1;
            pend_a[i] = a;
            pend_d[i] = d;
        end
    endtask

    // One clock: drive, model the cycle at negedge, return at posedge+1.
    task automatic step(input logic stall_in, input logic rst_in);
        logic [N-1:0] exp_g;
        int           gi;
        int unsigned  pc;
        logic         we;
        bus.req_valid = pend_v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*5 +: 5]   = pend_a[i];
            bus.req_data[i*32 +: 32] = pend_d[i];
        end
        bus.wb_stall = stall_in;
        rst = rst_in;
        @(negedge clk);
        exp_g = '0;
        gi = -1;
        if (!rst_in && !stall_in) begin
            for (int unsigned off = 1; off <= N; off++) begin
                int unsigned j;
                j = (last_g + off) % N;
                if (gi < 0 && pend_v[j]) gi = int'(j);
            end
        end
        if (gi >= 0) exp_g[gi] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_g));
        pc = 0;
        for (int i = 0; i < N; i++) pc += pend_v[i] ? 1 : 0;
        if (gi >= 0) begin
`ifdef RF_WB_ZERO_FILTER_EN
            we = (pend_a[gi] != 5'd0);
`else
            we = 1'b1;
`endif
            if (we) wq.push_back('{a: pend_a[gi], d: pend_d[gi], due: cyc + 1});
            pend_v[gi] = 1'b0;
            last_g = gi;
        end
        if (rst_in) begin
            cnt_m = 0;
            last_g = N - 1;
        end else if (pc >= 2 && !stall_in && cnt_m < CMAX) begin
            cnt_m++;
        end
        cq.push_back(cnt_m);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare registered outputs against queued expectations.
    initial begin
        while (running) begin
            @(posedge clk);
            #1;
            if (cq.size() != 0) check("conflict_cnt", 64'(conflict_cnt), 64'(cq.pop_front()));
            if (bus.RegWrite === 1'b1) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 64'(bus.RdAddr), 64'hFFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("RdAddr", 64'(bus.RdAddr), 64'(e.a));
                    check("RdData", 64'(bus.RdData), 64'(e.d));
                    check("write_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (wq.size() != 0 && wq[0].due <= cyc) begin
                wr_t e;
                e = wq.pop_front();
                check("missing_write", 64'(bus.RegWrite), 64'(1));
            end
        end
    end

    initial begin
        pend_v = '0;
        for (int i = 0; i < N; i++) begin
            pend_a[i] = '0;
            pend_d[i] = '0;
        end
        last_g = N - 1;
        cnt_m  = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.wb_stall  = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset_RdAddr", 64'(bus.RdAddr), 64'(0));
        check("reset_RdData", 64'(bus.RdData), 64'(0));
        check("reset_RegWrite", 64'(bus.RegWrite), 64'(0));
        check("reset_cnt", 64'(conflict_cnt), 64'(0));

        // Single requester.
        arm(0, 5'd8, 32'hDEAD_BEEF);
        step(1'b0, 1'b0);
        check("single_RegWrite", 64'(bus.RegWrite), 64'(1));
        check("single_RdAddr", 64'(bus.RdAddr), 64'(8));

        // Contention between requesters 0 and 1 for 4 cycles.
        for (int k = 0; k < 4; k++) begin
            arm(0, 5'd3, 32'h3000 + k);
            arm(1, 5'd4, 32'h4000 + k);
            step(1'b0, 1'b0);
        end
        check("contention_cnt", 64'(conflict_cnt), 64'(4));

        // Stall with both valid, then release.
        arm(0, 5'd5, 32'h5555);
        arm(1, 5'd6, 32'h6666);
        repeat (3) step(1'b1, 1'b0);
        check("stall_cnt", 64'(conflict_cnt), 64'(4));
        repeat (N + 1) step(1'b0, 1'b0);

        // Write to R0.
        arm(0, 5'd0, 32'h1234);
        step(1'b0, 1'b0);

        // Reset mid-stream.
        arm(1, 5'd9, 32'h9999);
        arm(2, 5'd10, 32'hAAAA);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_cnt", 64'(conflict_cnt), 64'(0));
        arm(0, 5'd11, 32'hBBBB);
        step(1'b0, 1'b0);
        repeat (N) step(1'b0, 1'b0);

        // Counter saturation.
        for (int k = 0; k < 20; k++) begin
            arm(0, 5'd12, $urandom);
            arm(1, 5'd13, $urandom);
            step(1'b0, 1'b0);
        end
        check("sat_cnt", 64'(conflict_cnt), 64'(CMAX));
        step(1'b0, 1'b1);

        // Randomized traffic with occasional stalls and resets.
        for (int k = 0; k < 800; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    logic [4:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    arm(i, a, $urandom);
                end
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
        end

        repeat (3) step(1'b0, 1'b0);
        running = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(wq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
